queue_pop_mux: RTL and testbench

QUEUE_POP_MUX -- requirements
Module: queue_pop_mux

---
 rtl/queue_pop_mux_pkg.sv | 7 +
 rtl/skid_buffer2.sv | 39 +++
 rtl/queue_pop_mux.sv | 57 +++++
 tb/tb_queue_pop_mux.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/queue_pop_mux_pkg.sv
// queue_pop_mux_pkg: shared defaults and output-buffer occupancy encoding
package queue_pop_mux_pkg;
   localparam int QUEUE_QUANTITY_DEF = 4;
   localparam int DATA_BITS_DEF = 8;
   localparam int SEL_BITS = $clog2(QUEUE_QUANTITY_DEF);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
endpackage

// File: rtl/skid_buffer2.sv
// skid_buffer2: two-entry in-order output buffer, head entry drives rdata
module skid_buffer2
   import queue_pop_mux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             write,
   input  logic             read,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output occ_t             occupancy,
   output logic             valid
);
   occ_t state_nxt;
   logic rd;
   logic [WIDTH-1:0] mem1;
   assign rd = read & (occupancy != EMPTY);
   always_ff @(posedge clk or negedge rst)
      if (!rst) occupancy <= EMPTY;
      else occupancy <= state_nxt;
   always_comb begin
      state_nxt = occupancy;
      if (write && !rd) state_nxt = (occupancy == EMPTY) ? ONE : TWO;
      else if (rd && !write) state_nxt = (occupancy == TWO) ? ONE : EMPTY;
   end
   always_comb valid = occupancy != EMPTY;
   // the head shifts from mem1 on a read in TWO, otherwise takes the write when it becomes head
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rdata <= '0;
         mem1 <= '0;
      end else begin
         if (rd && occupancy == TWO) rdata <= mem1;
         else if (write && (rd || occupancy == EMPTY)) rdata <= wdata;
         if (write && ((occupancy == ONE && !rd) || (occupancy == TWO && rd))) mem1 <= wdata;
      end
endmodule

// File: rtl/queue_pop_mux.sv
// queue_pop_mux: pops the granted FIFO when downstream space allows and buffers the word with its source index
module queue_pop_mux
   import queue_pop_mux_pkg::*;
#(
   parameter int QUEUE_QUANTITY = QUEUE_QUANTITY_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enb,
   input  logic [$clog2(QUEUE_QUANTITY)-1:0]   selector,
   input  logic                                selector_enb,
   input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
   input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
   output logic [QUEUE_QUANTITY-1:0]           pop,
   output logic [DATA_BITS-1:0]                data_out,
   output logic [$clog2(QUEUE_QUANTITY)-1:0]   dest,
   output logic                                valid_out,
   input  logic                                ready_in,
   output logic [15:0]                         pop_total
);
   localparam int SW = $clog2(QUEUE_QUANTITY);
   localparam logic [SW:0] QQ_W = QUEUE_QUANTITY[SW:0];
   logic inflight, rd, sel_ok, space_ok, pop_en;
   logic [SW-1:0] inflight_idx;
   logic [2:0] load;
   logic [SW+DATA_BITS-1:0] head;
   occ_t occupancy;
   assign rd = valid_out & ready_in;
   // words already buffered or in flight, minus the one leaving now, must leave a free slot
   assign load = {1'b0, occupancy} + {2'b0, inflight} - {2'b0, rd};
   assign space_ok = load < 3'd2;
   assign sel_ok = {1'b0, selector} < QQ_W;
   assign pop_en = rst & enb & selector_enb & sel_ok & space_ok & !buf_empty[selector];
   assign pop = pop_en ? {{(QUEUE_QUANTITY-1){1'b0}}, 1'b1} << selector : '0;
   assign {dest, data_out} = head;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         inflight <= 1'b0;
         inflight_idx <= '0;
         pop_total <= '0;
      end else begin
         inflight <= pop_en;
         inflight_idx <= selector;
         pop_total <= pop_total + {15'd0, pop_en};
      end
   skid_buffer2 #(.WIDTH(SW + DATA_BITS)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .write     (inflight),
      .read      (rd),
      .wdata     ({inflight_idx, fifo_data[inflight_idx*DATA_BITS +: DATA_BITS]}),
      .rdata     (head),
      .occupancy (occupancy),
      .valid     (valid_out)
   );
endmodule

// File: tb/tb_queue_pop_mux.sv
// tb_queue_pop_mux: directed scenario tasks with hand-computed expectations against a registered-read FIFO model
module tb_queue_pop_mux;
   logic clk = 0, rst = 0, enb = 0, selector_enb = 0, ready_in = 0;
   logic [1:0] selector = 0;
   logic [3:0] buf_empty = 4'hF;
   logic [31:0] fifo_data;
   logic [3:0] pop;
   logic [7:0] data_out;
   logic [1:0] dest;
   logic valid_out;
   logic [15:0] pop_total;
   logic [7:0] base [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
   logic [7:0] cnt [4];
   int pass = 0, total = 0;

   always #5 clk = ~clk;

   queue_pop_mux dut (
      .clk(clk), .rst(rst), .enb(enb), .selector(selector), .selector_enb(selector_enb),
      .buf_empty(buf_empty), .fifo_data(fifo_data), .pop(pop), .data_out(data_out),
      .dest(dest), .valid_out(valid_out), .ready_in(ready_in), .pop_total(pop_total)
   );

   // each queue i yields base[i], base[i]+1, ... one cycle after its pop
   always @(posedge clk or negedge rst)
      if (!rst) begin
         for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
         fifo_data <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (pop[i]) begin
               fifo_data[i*8 +: 8] <= base[i] + cnt[i];
               cnt[i] <= cnt[i] + 8'd1;
            end
      end

   task automatic apply_reset;
      @(negedge clk);
      rst = 0; enb = 1; selector_enb = 0; selector = 0; buf_empty = 4'h0; ready_in = 1;
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 0; enb = 1; selector = 1; selector_enb = 1; buf_empty = 4'h0; ready_in = 1;
      #1;
      total++; if (pop !== 4'b0) $display("FAIL reset_pop got %b want 0000", pop); else pass++;
      total++; if (valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_out); else pass++;
      total++; if (pop_total !== 16'd0) $display("FAIL reset_pop_total got %0d want 0", pop_total); else pass++;
      total++; if (data_out !== 8'd0) $display("FAIL reset_data got %h want 00", data_out); else pass++;
      total++; if (dest !== 2'd0) $display("FAIL reset_dest got %0d want 0", dest); else pass++;
      @(negedge clk);
      selector_enb = 0; rst = 1;
   endtask

   task automatic test_single;
      apply_reset();
      base[2] = 8'hA5;
      @(negedge clk); selector = 2; selector_enb = 1; #1;
      total++; if (pop !== 4'b0100) $display("FAIL single_pop got %b want 0100", pop); else pass++;
      total++; if (valid_out !== 1'b0) $display("FAIL single_valid_n got %b want 0", valid_out); else pass++;
      @(negedge clk); selector_enb = 0; #1;
      total++; if ({pop, valid_out} !== 5'b0) $display("FAIL single_n1 got pop=%b valid=%b want 0000/0", pop, valid_out); else pass++;
      @(negedge clk); #1;
      total++; if ({valid_out, dest, data_out} !== {1'b1, 2'd2, 8'hA5})
         $display("FAIL single_out got valid=%b dest=%0d data=%h want 1/2/a5", valid_out, dest, data_out); else pass++;
      @(negedge clk); #1;
      total++; if (valid_out !== 1'b0) $display("FAIL single_drained got %b want 0", valid_out); else pass++;
      total++; if (pop_total !== 16'd1) $display("FAIL single_total got %0d want 1", pop_total); else pass++;
   endtask

   task automatic test_empty;
      apply_reset();
      buf_empty = 4'hF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); selector = 2'(c); selector_enb = 1; #1;
         total++; if ({pop, valid_out} !== 5'b0) $display("FAIL empty_q%0d got pop=%b valid=%b want 0000/0", c, pop, valid_out); else pass++;
      end
      @(negedge clk); selector_enb = 0; #1;
      total++; if (pop_total !== 16'd0) $display("FAIL empty_total got %0d want 0", pop_total); else pass++;
   endtask

   task automatic test_backpressure;
      logic [7:0] exp;
      int got;
      apply_reset();
      base[0] = 8'h10;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); selector = 0; selector_enb = 1; ready_in = 0; #1;
         total++; if (pop !== ((c < 2) ? 4'b0001 : 4'b0000)) $display("FAIL bp_pop_c%0d got %b", c, pop); else pass++;
         if (c >= 2) begin
            total++; if ({valid_out, data_out} !== {1'b1, 8'h10})
               $display("FAIL bp_hold_c%0d got valid=%b data=%h want 1/10", c, valid_out, data_out); else pass++;
         end
      end
      exp = 8'h10; got = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk); ready_in = 1; selector_enb = (c < 8); #1;
         total++; if (pop !== ((c < 8) ? 4'b0001 : 4'b0000)) $display("FAIL bp_resume_c%0d got %b", c, pop); else pass++;
         if (valid_out) begin
            total++; if ({dest, data_out} !== {2'd0, exp})
               $display("FAIL bp_order got dest=%0d data=%h want 0/%h", dest, data_out, exp); else pass++;
            exp++; got++;
         end
      end
      total++; if (got !== 10) $display("FAIL bp_count got %0d want 10", got); else pass++;
      total++; if (pop_total !== 16'd10) $display("FAIL bp_total got %0d want 10", pop_total); else pass++;
      total++; if (valid_out !== 1'b0) $display("FAIL bp_drained got %b want 0", valid_out); else pass++;
   endtask

   task automatic test_stream;
      apply_reset();
      base[0] = 8'h80; base[1] = 8'h91; base[2] = 8'hA2; base[3] = 8'hB3;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk); selector = 2'(c); selector_enb = (c < 4); #1;
         total++; if (pop !== ((c < 4) ? 4'(1 << c) : 4'b0)) $display("FAIL stream_pop_c%0d got %b", c, pop); else pass++;
         if (c >= 2 && c < 6) begin
            total++; if ({valid_out, dest, data_out} !== {1'b1, 2'(c - 2), base[c-2]})
               $display("FAIL stream_out_c%0d got valid=%b dest=%0d data=%h want 1/%0d/%h", c, valid_out, dest, data_out, c - 2, base[c-2]); else pass++;
         end else begin
            total++; if (valid_out !== 1'b0) $display("FAIL stream_idle_c%0d got %b want 0", c, valid_out); else pass++;
         end
      end
      total++; if (pop_total !== 16'd4) $display("FAIL stream_total got %0d want 4", pop_total); else pass++;
   endtask

   task automatic test_enb;
      apply_reset();
      base[1] = 8'h5A;
      @(negedge clk); selector = 1; selector_enb = 1; #1;
      total++; if (pop !== 4'b0010) $display("FAIL enb_pop got %b want 0010", pop); else pass++;
      @(negedge clk); enb = 0; #1;
      total++; if (pop !== 4'b0) $display("FAIL enb_block got %b want 0000", pop); else pass++;
      @(negedge clk); #1;
      total++; if ({pop, valid_out, data_out} !== {4'b0, 1'b1, 8'h5A})
         $display("FAIL enb_capture got pop=%b valid=%b data=%h want 0000/1/5a", pop, valid_out, data_out); else pass++;
      @(negedge clk); #1;
      total++; if ({valid_out, pop_total} !== {1'b0, 16'd1}) $display("FAIL enb_done got valid=%b total=%0d want 0/1", valid_out, pop_total); else pass++;
      selector_enb = 0; enb = 1;
   endtask

   task automatic test_reset_midflight;
      apply_reset();
      base[1] = 8'h33; base[3] = 8'h77;
      @(negedge clk); selector = 1; selector_enb = 1; #1;
      total++; if (pop !== 4'b0010) $display("FAIL mid_pop got %b want 0010", pop); else pass++;
      @(negedge clk); selector_enb = 0; rst = 0; #1;
      total++; if ({pop, valid_out, pop_total} !== 21'd0)
         $display("FAIL mid_reset got pop=%b valid=%b total=%0d want 0", pop, valid_out, pop_total); else pass++;
      @(negedge clk); rst = 1; selector = 3; selector_enb = 1; #1;
      total++; if (pop !== 4'b1000) $display("FAIL mid_first_pop got %b want 1000", pop); else pass++;
      @(negedge clk); selector_enb = 0; #1;
      total++; if (valid_out !== 1'b0) $display("FAIL mid_ghost got valid=%b dest=%0d want 0", valid_out, dest); else pass++;
      @(negedge clk); #1;
      total++; if ({valid_out, dest, data_out} !== {1'b1, 2'd3, 8'h77})
         $display("FAIL mid_out got valid=%b dest=%0d data=%h want 1/3/77", valid_out, dest, data_out); else pass++;
      @(negedge clk); #1;
      total++; if ({valid_out, pop_total} !== {1'b0, 16'd1}) $display("FAIL mid_done got valid=%b total=%0d want 0/1", valid_out, pop_total); else pass++;
   endtask

   task automatic test_wrap;
      apply_reset();
      @(negedge clk); selector = 0; selector_enb = 1; ready_in = 1;
      repeat (65535) @(negedge clk);
      #1;
      total++; if (pop_total !== 16'hFFFF) $display("FAIL wrap_max got %h want ffff", pop_total); else pass++;
      @(negedge clk); #1;
      total++; if (pop_total !== 16'h0000) $display("FAIL wrap_zero got %h want 0000", pop_total); else pass++;
      selector_enb = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_empty();
      test_backpressure();
      test_stream();
      test_enb();
      test_reset_midflight();
      test_wrap();
      test_reset();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
